// File: rtl/idelay_tap_scanner_if.sv
// Result stream of the IDELAY tap scanner.
// A record moves when res_valid && res_ready; the producer holds the payload until then.
interface idelay_tap_scanner_if #(
  parameter int TAP_BITS = 5,
  parameter int CNT_BITS = 9
);
  logic                res_valid;
  logic                res_ready;
  logic [TAP_BITS-1:0] res_tap;
  logic [CNT_BITS-1:0] res_ones;
  logic [CNT_BITS-1:0] res_edges;

  modport master (
    output res_valid,
    output res_tap,
    output res_ones,
    output res_edges,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_tap,
    input  res_ones,
    input  res_edges,
    output res_ready
  );
endinterface

// File: rtl/idelay_tap_scanner.sv
// IDELAYE2 (VAR_LOAD) tap sweeper.
// For each tap 0..NUM_TAPS-1 the scanner loads the tap and waits SETTLE_CYCLES.
// It then samples DATAOUT for SAMPLE_CYCLES and reports the ones count and the
// transition count on the result stream. Losing cal_rdy ends the sweep early.
module idelay_tap_scanner #(
  parameter int  TAP_BITS      = 5,
  parameter int  NUM_TAPS      = 32,
  parameter int  SETTLE_CYCLES = 8,
  parameter int  SAMPLE_CYCLES = 256,
  localparam int CNT_BITS      = $clog2(SAMPLE_CYCLES + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cal_rdy,
  input  logic                start,
  input  logic                dly_data,
  output logic                dly_ld,
  output logic [TAP_BITS-1:0] dly_cntvalue,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  idelay_tap_scanner_if.master res
);

  // One phase counter serves both the settle and the sample phase.
  localparam int CYC_MAX  = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
  localparam int CYC_BITS = $clog2(CYC_MAX + 1);

  localparam logic [CYC_BITS-1:0] SETTLE_LAST = CYC_BITS'(SETTLE_CYCLES - 1);
  localparam logic [CYC_BITS-1:0] SAMPLE_LAST = CYC_BITS'(SAMPLE_CYCLES - 1);
  localparam logic [TAP_BITS-1:0] TAP_LAST    = TAP_BITS'(NUM_TAPS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_SAMPLE,
    S_REPORT
  } state_t;

  state_t              state_reg,   state_next;
  logic [TAP_BITS-1:0] tap_reg,     tap_next;
  logic [CYC_BITS-1:0] cyc_reg,     cyc_next;
  logic [CNT_BITS-1:0] ones_reg,    ones_next;
  logic [CNT_BITS-1:0] edges_reg,   edges_next;
  logic                lost_reg,    lost_next;
  logic                done_reg,    done_next;
  logic                aborted_reg, aborted_next;

  // Two-stage capture of DATAOUT. d_q is the current sample and d_qq the
  // previous one, so an edge is d_q != d_qq.
  logic d_q;
  logic d_qq;

  // Sample pipeline runs every cycle regardless of the sweep state.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q  <= 1'b0;
      d_qq <= 1'b0;
    end else begin
      d_q  <= dly_data;
      d_qq <= d_q;
    end
  end

  // State, tap index, phase counter and result counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      tap_reg     <= '0;
      cyc_reg     <= '0;
      ones_reg    <= '0;
      edges_reg   <= '0;
      lost_reg    <= 1'b0;
      done_reg    <= 1'b0;
      aborted_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      tap_reg     <= tap_next;
      cyc_reg     <= cyc_next;
      ones_reg    <= ones_next;
      edges_reg   <= edges_next;
      lost_reg    <= lost_next;
      done_reg    <= done_next;
      aborted_reg <= aborted_next;
    end
  end

  // Next-state logic: sweep sequencing, sampling and cal_rdy loss handling.
  always_comb begin
    state_next   = state_reg;
    tap_next     = tap_reg;
    cyc_next     = cyc_reg;
    ones_next    = ones_reg;
    edges_next   = edges_reg;
    lost_next    = lost_reg;
    done_next    = 1'b0;
    aborted_next = 1'b0;

    unique case (state_reg)
      S_IDLE: begin
        lost_next = 1'b0;
        if (start && cal_rdy) begin
          tap_next   = '0;
          state_next = S_LOAD;
        end
      end

      S_LOAD: begin
        ones_next  = '0;
        edges_next = '0;
        cyc_next   = '0;
        state_next = S_SETTLE;
      end

      S_SETTLE: begin
        if (cyc_reg == SETTLE_LAST) begin
          cyc_next   = '0;
          state_next = S_SAMPLE;
        end else begin
          cyc_next = cyc_reg + 1'b1;
        end
      end

      S_SAMPLE: begin
        // Exactly SAMPLE_CYCLES increments, so neither counter can exceed
        // SAMPLE_CYCLES and no wrap is possible.
        ones_next  = ones_reg + CNT_BITS'(d_q);
        edges_next = edges_reg + CNT_BITS'(d_q ^ d_qq);
        if (cyc_reg == SAMPLE_LAST) begin
          cyc_next   = '0;
          state_next = S_REPORT;
        end else begin
          cyc_next = cyc_reg + 1'b1;
        end
      end

      S_REPORT: begin
        // A cal_rdy drop here is remembered. The pending result is still
        // delivered, but the sweep ends at the handshake.
        if (!cal_rdy) begin
          lost_next = 1'b1;
        end
        if (res.res_ready) begin
          lost_next = 1'b0;
          if (lost_reg || !cal_rdy) begin
            tap_next     = '0;
            aborted_next = 1'b1;
            state_next   = S_IDLE;
          end else if (tap_reg == TAP_LAST) begin
            tap_next   = '0;
            done_next  = 1'b1;
            state_next = S_IDLE;
          end else begin
            tap_next   = tap_reg + 1'b1;
            state_next = S_LOAD;
          end
        end
      end

      default: begin
        tap_next   = '0;
        state_next = S_IDLE;
      end
    endcase

    // Losing calibration before the result exists discards this tap.
    if (!cal_rdy && (state_reg == S_LOAD || state_reg == S_SETTLE || state_reg == S_SAMPLE)) begin
      tap_next     = '0;
      cyc_next     = '0;
      aborted_next = 1'b1;
      state_next   = S_IDLE;
    end
  end

  // Outputs decoded from registered state only.
  // Nothing combinationally depends on inputs.
  assign dly_ld        = (state_reg == S_LOAD);
  assign busy          = (state_reg != S_IDLE);
  assign dly_cntvalue  = busy ? tap_reg : '0;
  assign done          = done_reg;
  assign aborted       = aborted_reg;
  assign res.res_valid = (state_reg == S_REPORT);
  assign res.res_tap   = tap_reg;
  assign res.res_ones  = ones_reg;
  assign res.res_edges = edges_reg;

endmodule

// File: tb/tb_idelay_tap_scanner.sv
// Testbench for idelay_tap_scanner.
// Each sweep scenario comes from a table row. Every result, load pulse and
// done/aborted pulse is compared with values computed from the recorded
// DATAOUT history. The sample windows are derived from the sweep timing
// arithmetic.
module tb_idelay_tap_scanner;
  localparam int TAP_BITS = 5;
  localparam int NUM_TAPS = 32;
  localparam int S        = 8;
  localparam int N        = 256;
  localparam int CNT_BITS = $clog2(N + 1);
  localparam int P        = 1 + S + N + 1;   // cycles per tap with no backpressure
  localparam int HIST     = 65536;

  logic                clk      = 1'b0;
  logic                rst      = 1'b1;
  logic                cal_rdy  = 1'b0;
  logic                start    = 1'b0;
  logic                dly_data = 1'b0;
  logic                dly_ld;
  logic [TAP_BITS-1:0] dly_cntvalue;
  logic                busy;
  logic                done;
  logic                aborted;

  idelay_tap_scanner_if #(.TAP_BITS(TAP_BITS), .CNT_BITS(CNT_BITS)) res_if ();

  idelay_tap_scanner #(
    .TAP_BITS     (TAP_BITS),
    .NUM_TAPS     (NUM_TAPS),
    .SETTLE_CYCLES(S),
    .SAMPLE_CYCLES(N)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cal_rdy     (cal_rdy),
    .start       (start),
    .dly_data    (dly_data),
    .dly_ld      (dly_ld),
    .dly_cntvalue(dly_cntvalue),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted),
    .res         (res_if)
  );

  always #5 clk = ~clk;

  // Scenario record: stimulus settings plus expected outcome counts.
  // A value of -1 means the setting is unused or the result comes from the model.
  typedef struct {
    int dmode;        // 0 toggle, 1 high, 2 low, 3 random
    int stall_tap;
    int stall_len;
    int poke_tap;     // extra start pulse during this tap's SAMPLE
    int abort_tap;
    int abort_rep;    // 1: drop cal_rdy in REPORT, 0: in SAMPLE
    int rst_tap;      // reset during this tap's SETTLE
    int exp_n;
    int exp_done;
    int exp_ab;
    int exp_ones;
    int exp_edges;
  } row_t;

  typedef struct { int tap; int ones; int edges; int at; } hs_t;
  typedef struct { int cv; int at; } ld_t;

  row_t  rows [7];
  string row_name [7];
  row_t  cur;

  bit    din_hist [HIST];
  int    edge_n = 0;
  hs_t   hs_q [$];
  ld_t   ld_q [$];
  int    done_cnt, done_at, ab_cnt, ab_at;
  int    ab_busy;
  int    n_checks = 0;
  int    n_fail   = 0;

  // Record the value of DATAOUT seen at every rising edge.
  always @(posedge clk) begin
    if (edge_n < HIST) din_hist[edge_n] <= dly_data;
    edge_n <= edge_n + 1;
  end

  // Observe the DUT between edges. Inputs for the next edge are already driven.
  always @(negedge clk) begin
    #2;
    if (res_if.res_valid && res_if.res_ready)
      hs_q.push_back('{int'(res_if.res_tap), int'(res_if.res_ones), int'(res_if.res_edges), edge_n - 1});
    if (dly_ld)
      ld_q.push_back('{int'(dly_cntvalue), edge_n - 1});
    if (done) begin
      done_cnt = done_cnt + 1;
      done_at  = edge_n - 1;
    end
    if (aborted) begin
      ab_cnt  = ab_cnt + 1;
      ab_at   = edge_n - 1;
      ab_busy = int'(busy);
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_dly_ld"},    int'(dly_ld), 0);
    check({tag, "_cntvalue"},  int'(dly_cntvalue), 0);
    check({tag, "_busy"},      int'(busy), 0);
    check({tag, "_done"},      int'(done), 0);
    check({tag, "_aborted"},   int'(aborted), 0);
    check({tag, "_res_valid"}, int'(res_if.res_valid), 0);
    check({tag, "_res_tap"},   int'(res_if.res_tap), 0);
    check({tag, "_res_ones"},  int'(res_if.res_ones), 0);
    check({tag, "_res_edges"}, int'(res_if.res_edges), 0);
  endtask

  task automatic drive_data(input int m);
    case (m)
      0:       dly_data = ~dly_data;
      1:       dly_data = 1'b1;
      2:       dly_data = 1'b0;
      default: dly_data = 1'($urandom_range(0, 1));
    endcase
  endtask

  // Edge after which tap k's LOAD is visible, for a sweep whose start was taken at edge e.
  function automatic int base_of(input int e, input int k);
    return e + k * P + ((cur.stall_tap >= 0 && k > cur.stall_tap) ? cur.stall_len : 0);
  endfunction

  // Edge after which tap k's result is offered together with res_ready high.
  function automatic int at_of(input int e, input int k);
    return base_of(e, k) + S + N + 1 + ((k == cur.stall_tap) ? cur.stall_len : 0);
  endfunction

  // The sample window covers values captured at edges b+S+1 .. b+S+N.
  function automatic int model_ones(input int b);
    int s = 0;
    if (cur.exp_ones >= 0) return cur.exp_ones;
    for (int i = 0; i < N; i++) s += int'(din_hist[b + S + 1 + i]);
    return s;
  endfunction

  function automatic int model_edges(input int b);
    int s = 0;
    if (cur.exp_edges >= 0) return cur.exp_edges;
    for (int i = 0; i < N; i++)
      s += (din_hist[b + S + 1 + i] != din_hist[b + S + i]) ? 1 : 0;
    return s;
  endfunction

  task automatic run_row(input int ri);
    int e, cyc, tail, rep, x_ab, bo, n_ld, nres;
    bit rst_pend, timeout;
    cur      = rows[ri];
    hs_q.delete();
    ld_q.delete();
    done_cnt = 0; done_at = -1; ab_cnt = 0; ab_at = -1; ab_busy = 0;
    cal_rdy  = 1'b1;
    res_if.res_ready = 1'b1;
    start    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      drive_data(cur.dmode);
    end
    @(negedge clk); #1;
    drive_data(cur.dmode);
    start = 1'b1;
    e     = edge_n;
    rep   = (cur.stall_tap >= 0) ? base_of(e, cur.stall_tap) + S + N + 1 : -100;
    x_ab  = (cur.abort_tap >= 0 && cur.abort_rep == 0) ? base_of(e, cur.abort_tap) + S + 1 + 100 : -100;
    tail = -1; cyc = 0; rst_pend = 0; timeout = 0;
    while (tail < 3) begin
      @(negedge clk); #1;
      start = 1'b0;
      drive_data(cur.dmode);
      cyc++;
      if (rst_pend) begin
        check_zero({row_name[ri], "_midrst"});
        rst      = 1'b0;
        rst_pend = 0;
        tail     = 0;
      end
      if (cur.poke_tap >= 0 && edge_n == base_of(e, cur.poke_tap) + S + 1 + 50)
        start = 1'b1;
      if (cur.stall_tap >= 0 && edge_n >= rep + 1 && edge_n <= rep + cur.stall_len) begin
        res_if.res_ready = 1'b0;
        bo = base_of(e, cur.stall_tap);
        check("stall_valid", int'(res_if.res_valid), 1);
        check("stall_tap",   int'(res_if.res_tap), cur.stall_tap);
        check("stall_ones",  int'(res_if.res_ones), model_ones(bo));
        check("stall_edges", int'(res_if.res_edges), model_edges(bo));
        check("stall_no_ld", int'(dly_ld), 0);
      end else begin
        res_if.res_ready = 1'b1;
      end
      if (edge_n == x_ab) cal_rdy = 1'b0;
      if (cur.abort_rep == 1 && edge_n == rep + 1) cal_rdy = 1'b0;
      if (cur.rst_tap >= 0 && edge_n == base_of(e, cur.rst_tap) + 4) begin
        rst      = 1'b1;
        rst_pend = 1;
      end
      if (tail >= 0) tail++;
      else if (done_cnt > 0 || ab_cnt > 0) tail = 0;
      if (cyc > 9500) begin
        timeout = 1;
        break;
      end
    end
    check({row_name[ri], "_timeout"}, int'(timeout), 0);

    check({row_name[ri], "_nres"}, hs_q.size(), cur.exp_n);
    nres = (hs_q.size() < cur.exp_n) ? hs_q.size() : cur.exp_n;
    for (int k = 0; k < nres; k++) begin
      bo = base_of(e, k);
      $display("%s: tap %0d ones %0d edges %0d at edge %0d", row_name[ri],
               hs_q[k].tap, hs_q[k].ones, hs_q[k].edges, hs_q[k].at - e);
      check("res_tap",   hs_q[k].tap, k);
      check("res_ones",  hs_q[k].ones, model_ones(bo));
      check("res_edges", hs_q[k].edges, model_edges(bo));
      check("res_time",  hs_q[k].at, at_of(e, k));
    end

    n_ld = (cur.abort_tap >= 0) ? cur.abort_tap + 1 : (cur.rst_tap >= 0) ? cur.rst_tap + 1 : NUM_TAPS;
    check({row_name[ri], "_nld"}, ld_q.size(), n_ld);
    for (int k = 0; k < ld_q.size() && k < n_ld; k++) begin
      check("ld_cntvalue", ld_q[k].cv, k);
      check("ld_time",     ld_q[k].at, base_of(e, k));
    end

    check({row_name[ri], "_done_cnt"}, done_cnt, cur.exp_done);
    if (cur.exp_done > 0)
      check({row_name[ri], "_done_time"}, done_at,
            e + NUM_TAPS * P + ((cur.stall_tap >= 0) ? cur.stall_len : 0));
    check({row_name[ri], "_abort_cnt"}, ab_cnt, cur.exp_ab);
    if (cur.exp_ab > 0) begin
      check({row_name[ri], "_abort_time"}, ab_at,
            (cur.abort_rep == 1) ? rep + cur.stall_len + 1 : x_ab);
      check({row_name[ri], "_abort_busy"}, ab_busy, 0);
    end
    check({row_name[ri], "_end_busy"}, int'(busy), 0);
    cal_rdy = 1'b1;
    res_if.res_ready = 1'b1;
  endtask

  initial begin
    //            dm  stT stL poke abT abR rsT  n  dn ab  ones edges
    rows[0] = '{0,  -1,  0,  -1,  -1, 0,  -1, 32, 1, 0, 128, 256}; row_name[0] = "toggle";
    rows[1] = '{1,  -1,  0,   2,  -1, 0,  -1, 32, 1, 0, 256,   0}; row_name[1] = "high_poke";
    rows[2] = '{3,   3, 50,  -1,  -1, 0,  -1, 32, 1, 0,  -1,  -1}; row_name[2] = "rand_stall";
    rows[3] = '{3,  -1,  0,  -1,   5, 0,  -1,  5, 0, 1,  -1,  -1}; row_name[3] = "abort_sample";
    rows[4] = '{0,   5, 20,  -1,   5, 1,  -1,  6, 0, 1, 128, 256}; row_name[4] = "abort_report";
    rows[5] = '{3,  -1,  0,  -1,  -1, 0,  10, 10, 0, 0,  -1,  -1}; row_name[5] = "rst_settle";
    rows[6] = '{2,  -1,  0,  -1,  -1, 0,  -1, 32, 1, 0,   0,   0}; row_name[6] = "low";

    res_if.res_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    // A start request while calibration is not ready must be ignored.
    @(negedge clk); #1;
    cal_rdy = 1'b0;
    start   = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("gated_busy", int'(busy), 0);
      check("gated_ld",   int'(dly_ld), 0);
      @(negedge clk); #1;
    end

    for (int ri = 0; ri < 7; ri++) run_row(ri);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/idelay_tap_scanner.md
Name: idelay_tap_scanner

Overview:
- Sweeps one IDELAYE2 configured as IDELAY_TYPE "VAR_LOAD" through taps 0..NUM_TAPS-1.
- At each tap: loads the tap value, waits for the delay line to settle, samples DATAOUT for a fixed window, then emits a per-tap result (ones count, transition count) on a valid/ready stream.
- Sits between the IDELAY calibrator (gated by its rdy) and the IDELAYE2 control pins. It consumes the delayed test-toggle signal.
- Used for on-board characterisation of tap delay against the fixed-tap bring-up designs.

Parameters:
- TAP_BITS, 5, width of the IDELAYE2 CNTVALUEIN bus.
- NUM_TAPS, 32, number of taps swept (1..2**TAP_BITS).
- SETTLE_CYCLES, 8, idle cycles after each load before sampling (>=1).
- SAMPLE_CYCLES, 256, samples taken per tap (>=1).
- CNT_BITS, derived localparam = $clog2(SAMPLE_CYCLES+1), width of the result counters.

Ports:
- clk  in  1  fabric clock; same clock as the IDELAYE2 C pin and the calibrator refclk.
- rst  in  1  synchronous active-high reset.
- cal_rdy  in  1  IDELAYCTRL calibration done; must be high to start or continue a sweep.
- start  in  1  single-cycle sweep request.
- dly_data  in  1  IDELAYE2 DATAOUT.
- dly_ld  out  1  IDELAYE2 LD.
- dly_cntvalue  out  TAP_BITS  IDELAYE2 CNTVALUEIN.
- busy  out  1  high whenever state != IDLE.
- done  out  1  1-cycle pulse after the last tap's result has been accepted.
- aborted  out  1  1-cycle pulse when a sweep is terminated by cal_rdy loss.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer ready.
- res_tap  out  TAP_BITS  tap index of the result.
- res_ones  out  CNT_BITS  number of samples equal to 1.
- res_edges  out  CNT_BITS  number of sample-to-sample transitions.

Behaviour:

Clocking and reset:
- One clock; reset is synchronous and active-high (clk, rst).
- On rst: state=IDLE, tap=0, and all outputs are 0 (dly_ld, dly_cntvalue, busy, done, aborted, res_valid, res_tap, res_ones, res_edges).
- rst asserted mid-sweep takes effect on the next edge. No done or aborted pulse is generated.

Input sampling:
- dly_data is registered every cycle into d_q, then d_q into d_qq. Both flops run continuously, independent of state.

FSM:
- IDLE: if start && cal_rdy, then tap=0 and go to LOAD. start is ignored outside IDLE, and ignored while cal_rdy is low.
- LOAD, 1 cycle: dly_ld=1. dly_cntvalue=tap, held stable from LOAD through REPORT. Counters are cleared. Go to SETTLE.
- SETTLE: SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE: exactly SAMPLE_CYCLES cycles. Each cycle:
  - res_ones += d_q.
  - res_edges += (d_q != d_qq).
  - Then go to REPORT.
- REPORT:
  - res_valid=1, with res_tap/res_ones/res_edges held stable until res_valid && res_ready.
  - On handshake, if tap==NUM_TAPS-1: go to IDLE and pulse done.
  - Otherwise: tap+1, go to LOAD.
  - res_valid deasserts the cycle after the handshake.

Counters and timing:
- Counters saturate by construction; maximum value is SAMPLE_CYCLES and fits in CNT_BITS. No wrap.
- Per-tap latency with res_ready held high: 1 + SETTLE_CYCLES + SAMPLE_CYCLES + 1 cycles, i.e. 266 with defaults. First LOAD occurs the cycle after start.

cal_rdy loss:
- cal_rdy low during LOAD, SETTLE or SAMPLE: go to IDLE next cycle and pulse aborted. No result is emitted for that tap.
- cal_rdy low during REPORT: the pending result completes its handshake, then go to IDLE and pulse aborted instead of advancing. done is not pulsed.

Other rules:
- dly_ld is never asserted outside LOAD.
- dly_cntvalue returns to 0 on entering IDLE.

Test Plan:
1. Toggle test: after reset, cal_rdy=1, dly_data toggling every clk, res_ready=1, pulse start.
   - Expect 32 results with res_tap 0..31 in order.
   - Each result: res_ones=128, res_edges=256.
   - Results spaced 266 cycles apart.
   - done pulses once after tap 31.
   - dly_ld pulses 32 times, and dly_cntvalue equals res_tap at each pulse.
2. Constant-high test: dly_data=1 throughout.
   - Every result: res_ones=256, res_edges=0.
   - With dly_data=0 instead: res_ones=0, res_edges=0.
3. Backpressure: res_ready low for 50 cycles during tap 3's REPORT.
   - res_valid and the payload stay stable for those cycles.
   - No LOAD for tap 4 until the handshake.
   - Total sweep time grows by exactly 50 cycles.
4. Start gating: start pulses with cal_rdy=0, then start pulses during SAMPLE of tap 2.
   - First case: no sweep begins and busy stays 0.
   - Second case: no restart; the sweep continues to tap 31 unchanged.
5. Abort: drop cal_rdy mid-SAMPLE of tap 5.
   - Next cycle: state IDLE, aborted=1 for one cycle, busy=0.
   - No tap-5 result, no done.
   - Repeat with the drop during tap 5's REPORT while res_ready=0: the tap-5 result is delivered on the later handshake, then aborted pulses.
6. Reset mid-sweep: assert rst during SETTLE of tap 10.
   - Next edge: all outputs 0, no done or aborted pulse.
   - A new start sweeps again from tap 0.
